// File: rtl/spi_pkg.sv
// Shared defaults and state encoding for the SPI mode-3 slave receiver.
package spi_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus receive-side outputs; master drives the pins, slave drives the results.
// The miso wire exists only when SPI_MISO_EN is defined.
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              sclk;
  logic              cs;
  logic              mosi;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_busy;
  logic [CNT_W-1:0]  byte_cnt;
`ifdef SPI_MISO_EN
  logic              miso;
`endif

  modport slave (
    input  sclk, cs, mosi,
`ifdef SPI_MISO_EN
    output miso,
`endif
    output rx_data, rx_valid, rx_busy, byte_cnt
  );

  modport master (
    output sclk, cs, mosi,
`ifdef SPI_MISO_EN
    input  miso,
`endif
    input  rx_data, rx_valid, rx_busy, byte_cnt
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin with a history flop
// producing single-cycle rise/fall pulses aligned to the synchronized value.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              hist_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RST_VAL}};
      hist_q  <= RST_VAL;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], pin_i};
      hist_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = !hist_q &&  chain_q[STAGES-1];
  assign fall_o =  hist_q && !chain_q[STAGES-1];

endmodule

// File: rtl/spi_slave_top.sv
// SPI mode-3 (CPOL=1, CPHA=1) MSB-first slave receiver, oversampled in clk50m.
// Optional SPI_MISO_EN adds a transmitter echoing the previous word on miso.
module spi_slave_top
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic        clk50m,
  input logic        rst_n,
  spi_slave_if.slave bus
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  logic sclk_rise, cs_sync, cs_rise, cs_fall;
`ifdef SPI_MISO_EN
  logic sclk_fall;
`else
  logic sclk_fall_unused;
`endif
  logic sclk_sync_unused;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_sync;

  spi_state_e        state_q;
  logic [DATA_W-1:0] shift_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic [CNT_W-1:0]  byte_cnt_q;
  logic [DATA_W-1:0] word_d;
  logic              word_done;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk_i  (clk50m),
    .rst_n  (rst_n),
    .pin_i  (bus.sclk),
    .sync_o (sclk_sync_unused),
    .rise_o (sclk_rise),
`ifdef SPI_MISO_EN
    .fall_o (sclk_fall)
`else
    .fall_o (sclk_fall_unused)
`endif
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i  (clk50m),
    .rst_n  (rst_n),
    .pin_i  (bus.cs),
    .sync_o (cs_sync),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // mosi only needs its synchronized level; no edge history.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
  end
  assign mosi_sync = mosi_q[SYNC_STAGES-1];

  assign word_d    = {shift_q[DATA_W-2:0], mosi_sync};
  assign word_done = (state_q == ACTIVE) && sclk_rise && (bit_cnt_q == LAST_BIT);

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q    <= ACTIVE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
          end
        end
        ACTIVE: begin
          if (sclk_rise) begin
            shift_q <= word_d;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_q  <= word_d;
              rx_valid_q <= 1'b1;
              bit_cnt_q  <= '0;
              byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
          // A word finishing in the same cycle as cs rising is still strobed above.
          if (cs_rise) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_busy  = ~cs_sync;
  assign bus.byte_cnt = byte_cnt_q;

`ifdef SPI_MISO_EN
  logic [DATA_W-1:0] tx_q;
  logic              miso_q;

  // Falling sclk presents the next bit so the master sees it on the rising edge.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= '0;
      miso_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (cs_fall) tx_q <= rx_data_q;
    end else if (word_done) begin
      tx_q <= word_d;
    end else if (sclk_fall) begin
      miso_q <= tx_q[DATA_W-1];
      tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  assign bus.miso = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave_top.sv
// Self-checking bench: random SPI frames against a queue-based word model.
module tb_spi_slave_top;

  typedef struct {
    logic [7:0] data;
    logic [7:0] cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  exp_t       exp_q[$];
  logic [7:0] m_cnt  = 8'd0;
  logic [7:0] m_last = 8'd0;

  always #10 clk = ~clk;

  spi_slave_if bus ();

  spi_slave_top dut (
    .clk50m (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Every strobe must match the next expected word and its frame count.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got rx_data %0h with no word pending at %0t",
                 bus.rx_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("strobe_rx_data", bus.rx_data, e.data);
        check("strobe_byte_cnt", bus.byte_cnt, e.cnt);
      end
    end
  end

  task automatic start_frame();
    @(negedge clk);
    #3;
    bus.cs = 1'b0;
    m_cnt  = 8'd0;
    #50;
  endtask

  // Sends the top n bits of b MSB first; only complete words enter the model.
  task automatic send_bits(input logic [7:0] b, input int n);
    if (n == 8) begin
      m_cnt  = m_cnt + 8'd1;
      m_last = b;
      exp_q.push_back('{data: b, cnt: m_cnt});
    end
    for (int i = 0; i < n; i++) begin
      bus.sclk = 1'b0;
      bus.mosi = b[7-i];
      #50;
      bus.sclk = 1'b1;
      #50;
    end
  endtask

  task automatic end_frame();
    #50;
    check("rx_busy_active", bus.rx_busy, 1);
    bus.cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rx_busy_drop", bus.rx_busy, 0);
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_frame_end();
    wait_drain();
    check("frame_rx_data", bus.rx_data, m_last);
    check("frame_byte_cnt", bus.byte_cnt, m_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int         nb;
    int         ex;

    bus.sclk = 1'b1;
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;

    // Reset held: pin activity must not disturb outputs.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.cs   = i[0];
      bus.sclk = ~bus.sclk;
      bus.mosi = ~bus.mosi;
      @(negedge clk);
    end
    check("reset_rx_data", bus.rx_data, 0);
    check("reset_rx_valid", bus.rx_valid, 0);
    check("reset_rx_busy", bus.rx_busy, 0);
    check("reset_byte_cnt", bus.byte_cnt, 0);
    bus.cs   = 1'b1;
    bus.sclk = 1'b1;
    bus.mosi = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single word.
    start_frame();
    send_bits(8'hB5, 8);
    end_frame();
    check_frame_end();
    check("single_rx_data", bus.rx_data, 32'hB5);
    check("single_byte_cnt", bus.byte_cnt, 1);

    // Two words in one frame.
    start_frame();
    send_bits(8'hB5, 8);
    check("mid_frame_busy", bus.rx_busy, 1);
    send_bits(8'h10, 8);
    end_frame();
    check_frame_end();
    check("two_rx_data", bus.rx_data, 32'h10);
    check("two_byte_cnt", bus.byte_cnt, 2);

    // Partial word is dropped; next frame restarts the count.
    start_frame();
    send_bits(8'hA8, 5);
    end_frame();
    check_frame_end();
    check("partial_rx_data", bus.rx_data, 32'h10);
    check("partial_byte_cnt", bus.byte_cnt, 0);
    start_frame();
    send_bits(8'h3C, 8);
    end_frame();
    check_frame_end();
    check("after_partial_rx_data", bus.rx_data, 32'h3C);
    check("after_partial_byte_cnt", bus.byte_cnt, 1);

    // Reset in the middle of a word.
    start_frame();
    send_bits(8'hF0, 4);
    #20;
    rst_n  = 1'b0;
    bus.cs = 1'b1;
    #1;
    check("midreset_rx_data", bus.rx_data, 0);
    check("midreset_byte_cnt", bus.byte_cnt, 0);
    check("midreset_rx_busy", bus.rx_busy, 0);
    exp_q.delete();
    m_last = 8'd0;
    m_cnt  = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    start_frame();
    send_bits(8'hA5, 8);
    end_frame();
    check_frame_end();
    check("post_reset_rx_data", bus.rx_data, 32'hA5);
    check("post_reset_byte_cnt", bus.byte_cnt, 1);

    // Random frames, some ending in a partial word.
    for (int f = 0; f < 20; f++) begin
      nb = int'($urandom_range(1, 4));
      ex = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      start_frame();
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        send_bits(b, 8);
      end
      if (ex != 0) begin
        b = 8'($urandom);
        send_bits(b, ex);
      end
      end_frame();
      check_frame_end();
    end

    // byte_cnt wraps 255 -> 0 within one long frame.
    start_frame();
    for (int k = 0; k < 257; k++) begin
      b = 8'($urandom);
      send_bits(b, 8);
    end
    end_frame();
    check_frame_end();
    check("wrap_byte_cnt", bus.byte_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
